// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte engine: FSM state encoding,
// R/W bit values and the default device address.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic       I2C_READ        = 1'b1;
  localparam logic       I2C_WRITE       = 1'b0;
  localparam logic [6:0] DEFAULT_DEVADDR = 7'h50;
  localparam logic [6:0] GENERAL_CALL    = 7'h00;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and detects SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES clk from pin to sda_s; edge/condition outputs are combinational on the synced values.
// Ports: clk, rst_n, scl_raw, sda_raw in; scl_rise, scl_fall, start, stop, sda_s out.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_raw};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_raw};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Idle bus is high, so presetting to 1 avoids a spurious edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL must be stably high across both samples so a condition never coincides with an SCL edge.
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave bit engine: address match, byte deserialise/serialise, ACK/NACK generation.
// Latency: RxValid SYNC_STAGES+1 Clk after the raw 8th SCL rise; SdaOe updates the Clk after a synced SCL fall.
// Ports: Clk/Rst, Scl/SdaIn pins, SdaOe open-drain enable, Rx*/Tx* byte handshake to the memory stage, AckEn, RoW, Busy.
module i2c_slave_byte_engine
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVADDR     = DEFAULT_DEVADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl,
  input  logic       SdaIn,
  output logic       SdaOe,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       RxFirst,
  output logic       RoW,
  input  logic       AckEn,
  output logic       TxReq,
  input  logic [7:0] TxData,
  output logic       Busy
);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (Clk),
    .rst_n    (Rst),
    .scl_raw  (Scl),
    .sda_raw  (SdaIn),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       first_q, first_d;     // next received byte is the memory address
  logic       row_q, row_d;
  logic       busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d;
  logic       tx_req_q, tx_req_d;
  logic       ack_ph_q, ack_ph_d;   // ACK-bit SCL rise already seen
  logic       ack_smp_q, ack_smp_d; // RX: sampled AckEn; TX_ACK: master acked

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    first_d    = first_q;
    row_d      = row_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    tx_req_d   = 1'b0;
    ack_ph_d   = ack_ph_q;
    ack_smp_d  = ack_smp_q;

    if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      first_d   = 1'b0;
    end else if (stop) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      first_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
            // shift_q[6:0] holds the 7 address bits; sda_s is the R/W bit.
            if (shift_q[6:0] == DEVADDR && shift_q[6:0] != GENERAL_CALL) begin
              row_d   = sda_s;
              busy_d  = 1'b1;
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall && !ack_ph_q) sda_oe_d = 1'b1;
          if (scl_rise) begin
            ack_ph_d = 1'b1;
            if (row_q == I2C_READ) tx_req_d = 1'b1;
          end
          if (scl_fall && ack_ph_q) begin
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (row_q == I2C_READ) begin
              shift_d  = TxData;
              sda_oe_d = ~TxData[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
              state_d  = ST_RX;
            end
          end
        end
        ST_RX: if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {shift_q[6:0], sda_s};
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            ack_smp_d  = AckEn;
            ack_ph_d   = 1'b0;
            bit_cnt_d  = 3'd0;
            state_d    = ST_RX_ACK;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall && !ack_ph_q) sda_oe_d = ack_smp_q;
          if (scl_rise) ack_ph_d = 1'b1;
          if (scl_fall && ack_ph_q) begin
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ack_smp_q ? ST_RX : ST_WAIT_STOP;
          end
        end
        // Bit 7 is already on the line from the loading fall; each further fall presents the next bit.
        ST_TX: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
            state_d   = ST_TX_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
          if (scl_fall && ack_ph_q) begin
            shift_d   = TxData;
            sda_oe_d  = ~TxData[7];
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = ST_TX;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      first_q    <= 1'b0;
      row_q      <= I2C_WRITE;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      tx_req_q   <= 1'b0;
      ack_ph_q   <= 1'b0;
      ack_smp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      first_q    <= first_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      tx_req_q   <= tx_req_d;
      ack_ph_q   <= ack_ph_d;
      ack_smp_q  <= ack_smp_d;
    end
  end

  assign SdaOe   = sda_oe_q;
  assign RxData  = rx_data_q;
  assign RxValid = rx_valid_q;
  assign RxFirst = rx_first_q;
  assign RoW     = row_q;
  assign TxReq   = tx_req_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Directed bench for the I2C slave byte engine with a bus-level master model.
// Received bytes are checked through an expected-strobe queue; read bytes against the bits seen on SDA.
// The master waits fixed time per bit; the slave never stretches the clock.
module tb_i2c_slave_byte_engine;

  localparam time Q = 50ns;  // quarter SCL period (5 Clk)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, row, tx_req, busy;
  logic       ack_en;
  logic [7:0] tx_data;

  int errors = 0;
  int checks = 0;
  int tx_req_cnt = 0;
  logic [8:0] exp_q[$];  // {first, data}

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_byte_engine dut (
    .Clk     (clk),
    .Rst     (rst_n),
    .Scl     (scl_m),
    .SdaIn   (sda_line),
    .SdaOe   (sda_oe),
    .RxData  (rx_data),
    .RxValid (rx_valid),
    .RxFirst (rx_first),
    .RoW     (row),
    .AckEn   (ack_en),
    .TxReq   (tx_req),
    .TxData  (tx_data),
    .Busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RxValid strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rxvalid", {23'd0, rx_first, rx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, exp_q.pop_front()});
      end
    end
    if (tx_req) tx_req_cnt++;
  end

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; #(2*Q);
    sda_m = 1'b0; #Q;
    scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    #Q; sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #Q;
  endtask

  // One bit cycle starting and ending with SCL low; returns the line value at mid-high.
  task automatic i2c_bit(input logic b, output logic seen);
    #Q; sda_m = b;
    #Q; scl_m = 1'b1;
    #Q; seen = sda_line;
    #Q; scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic [7:0] next_tx, input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      b[i] = s;
    end
    tx_data = next_tx;
    i2c_bit(~master_ack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rd;
    int         req0;

    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; ack_en = 1'b1; tx_data = 8'h00;
    #25;
    chk("rst_sdaoe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rxvalid", {31'd0, rx_valid}, 32'd0);
    chk("rst_txreq", {31'd0, tx_req}, 32'd0);
    chk("rst_row", {31'd0, row}, 32'd0);
    chk("rst_rxdata", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    #100;

    // Write 0x12, 0x34 to device 0x50.
    i2c_start();
    write_byte(8'hA0, ack); chk("w_addr_ack", {31'd0, ack}, 32'd1);
    chk("w_busy", {31'd0, busy}, 32'd1);
    chk("w_row", {31'd0, row}, 32'd0);
    exp_q.push_back({1'b1, 8'h12});
    write_byte(8'h12, ack); chk("w_d0_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back({1'b0, 8'h34});
    write_byte(8'h34, ack); chk("w_d1_ack", {31'd0, ack}, 32'd1);
    chk("w_rxdata_held", {24'd0, rx_data}, 32'h34);
    i2c_stop();
    #100;
    chk("w_busy_stop", {31'd0, busy}, 32'd0);
    chk("w_all_strobes", exp_q.size(), 32'd0);

    // Foreign address and general call are ignored.
    i2c_start();
    write_byte(8'hA2, ack); chk("foreign_nack", {31'd0, ack}, 32'd0);
    chk("foreign_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h99, ack); chk("foreign_data_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'h00, ack); chk("gcall_nack", {31'd0, ack}, 32'd0);
    chk("gcall_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    #100;

    // Read 0xC5 then 0x3A; master NACKs the second byte.
    req0 = tx_req_cnt;
    tx_data = 8'hC5;
    i2c_start();
    write_byte(8'hA1, ack); chk("r_addr_ack", {31'd0, ack}, 32'd1);
    chk("r_row", {31'd0, row}, 32'd1);
    read_byte(8'h3A, 1'b1, rd); chk("r_byte0", {24'd0, rd}, 32'hC5);
    read_byte(8'hEE, 1'b0, rd); chk("r_byte1", {24'd0, rd}, 32'h3A);
    chk("r_txreq_cnt", tx_req_cnt - req0, 32'd2);
    #(2*Q);
    chk("r_release_after_nack", {31'd0, sda_oe}, 32'd0);
    chk("r_busy_until_stop", {31'd0, busy}, 32'd1);
    i2c_bit(1'b0, s);  // clocks in WAIT_STOP must not drive SDA
    chk("r_waitstop_quiet", {31'd0, s}, 32'd0);
    i2c_stop();
    #100;
    chk("r_busy_stop", {31'd0, busy}, 32'd0);

    // Write then repeated START into a read.
    i2c_start();
    write_byte(8'hA0, ack); chk("rs_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back({1'b1, 8'h07});
    write_byte(8'h07, ack); chk("rs_d0_ack", {31'd0, ack}, 32'd1);
    req0 = tx_req_cnt;
    tx_data = 8'h5A;
    i2c_rstart();
    write_byte(8'hA1, ack); chk("rs_raddr_ack", {31'd0, ack}, 32'd1);
    chk("rs_row", {31'd0, row}, 32'd1);
    chk("rs_txreq", tx_req_cnt - req0, 32'd1);
    read_byte(8'h00, 1'b0, rd); chk("rs_byte", {24'd0, rd}, 32'h5A);
    i2c_stop();
    #100;
    chk("rs_all_strobes", exp_q.size(), 32'd0);

    // Local NACK: byte is delivered but refused, later bytes ignored.
    ack_en = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack); chk("n_addr_ack", {31'd0, ack}, 32'd1);
    exp_q.push_back({1'b1, 8'h55});
    write_byte(8'h55, ack); chk("n_d0_nack", {31'd0, ack}, 32'd0);
    ack_en = 1'b1;
    write_byte(8'h66, ack); chk("n_d1_ignored", {31'd0, ack}, 32'd0);
    i2c_stop();
    #100;
    chk("n_all_strobes", exp_q.size(), 32'd0);

    // STOP after 4 data bits aborts the byte.
    i2c_start();
    write_byte(8'hA0, ack); chk("a_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 4; i++) i2c_bit(i[0], s);
    i2c_stop();
    #300;
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_no_strobe", exp_q.size(), 32'd0);
    // A fresh address after the abort must still be recognised.
    i2c_start();
    write_byte(8'hA0, ack); chk("a_recover_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    #100;

    // Asynchronous reset while the slave pulls SDA low.
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(i == 5 || i == 7, s);  // 0xA0
    #Q;
    chk("rst_pre_sdaoe", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sdaoe", {31'd0, sda_oe}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    #20;
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    #200;
    chk("end_no_strobe", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_engine.md
Name: i2c_slave_byte_engine

Overview:
- Bit-level front end of the I2C slave, directly upstream of the slave memory / address-match stage.
- Oversamples SCL/SDA on the system clock, detects START/STOP, deserialises bytes and matches the 7-bit device address.
- Generates ACK/NACK and hands received bytes to the memory stage as a one-cycle strobe plus data; fetches read bytes from it with a request strobe.
- Serialises read bytes onto SDA through an open-drain enable.

Parameters:
- DEVADDR, 7'h50, 7-bit slave device address.
- SYNC_STAGES, 2, synchroniser depth for SCL/SDA (minimum 2).

Ports:
- Clk  in  1  system clock; must be at least 8x the SCL frequency.
- Rst  in  1  asynchronous, active-low reset.
- Scl  in  1  raw SCL pin.
- SdaIn  in  1  raw SDA pin.
- SdaOe  out  1  1 = pull SDA low (open drain); 0 = release.
- RxData  out  8  last received data byte; holds until the next strobe.
- RxValid  out  1  one-cycle strobe: RxData is valid.
- RxFirst  out  1  qualifies RxValid: this is the first byte after the address (the memory address).
- RoW  out  1  R/W bit of the current transaction (1 = master read); held until the next START.
- AckEn  in  1  sampled at the 8th SCL rise of a write data byte: 1 = ACK, 0 = NACK.
- TxReq  out  1  one-cycle strobe: supply the next read byte on TxData.
- TxData  in  8  read byte; sampled on the SCL fall that ends the ACK bit.
- Busy  out  1  high from an addressed START until STOP.

Behaviour:
- Reset (Rst=0): SdaOe=0, RxData=8'h00, RxValid=0, RxFirst=0, RoW=0, TxReq=0, Busy=0, state=IDLE, bit counter=0, synchronisers preset to 1.
- Synchronisation and edge detection: Scl/SdaIn pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Bits are sampled on the SCL rise; SdaOe changes only on the cycle after the SCL fall.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- Transitions:
  - Any state, START (including repeated START): go to ADDR, clear bit counter, SdaOe=0, Busy unchanged.
  - Any state, STOP: go to IDLE, SdaOe=0, Busy=0.
  - ADDR: shift 8 bits MSB first. On the 8th SCL rise compare bits[7:1] with DEVADDR.
    - Match: latch RoW=bit0, Busy=1, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP; SdaOe stays 0.
  - ADDR_ACK: SdaOe=1 from the 8th SCL fall to the 9th SCL fall.
    - If RoW=1, TxReq pulses on the 9th SCL rise; TxData is loaded into the shift register on the 9th fall, then go to TX.
    - Otherwise go to RX with the first-byte flag set.
  - RX: on the 8th rise, RxData is updated, RxValid pulses for 1 Clk, and RxFirst equals the first-byte flag (flag cleared afterwards). AckEn is sampled in the same cycle.
  - RX_ACK: SdaOe = sampled AckEn for the 9th bit, then return to RX. A NACK leads to WAIT_STOP instead.
  - TX: SdaOe = ~shift[7] after each SCL fall; shift on each fall; after the 8th fall release SDA and go to TX_ACK.
  - TX_ACK: sample master SDA on the 9th rise.
    - 0 (ACK): pulse TxReq, load TxData on the 9th fall, go to TX.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SdaOe=0; leave only on STOP or START.
- Latency: RxValid occurs SYNC_STAGES+1 Clk after the raw 8th SCL rise. TxData must be stable from TxReq until the following SCL fall (at least half an SCL period).
- Boundaries:
  - START/STOP inside a byte aborts it: no RxValid, partial bits discarded.
  - A STOP immediately after the address (zero data bytes) produces no strobes.
  - The general call address 7'h00 is not matched.
  - SCL stretching by the master is tolerated because the block is edge-driven only.
  - Asserting Rst mid-transfer releases SDA within the same Clk (asynchronous).

Decomposition:
- Package i2c_pkg: state encoding, I2C_READ/I2C_WRITE constants, the default DEVADDR.
- Sub-module i2c_line_sync: parameterised synchroniser plus rise/fall and START/STOP detector for SCL/SDA. Instantiated once; its outputs are scl_rise, scl_fall, start, stop, sda_s.

Test Plan:
- Write to 0x50 (addr byte 0xA0), then 0x12, 0x34, STOP, AckEn=1 -> ACK on all 3 bytes; RxValid twice: 0x12 with RxFirst=1, 0x34 with RxFirst=0; Busy drops after STOP.
- Address 0x51 (byte 0xA2) -> no ACK (SdaOe stays 0), no strobes, Busy=0, idle after STOP.
- Read 0xA1, TxData=0xC5, then 0x3A, master ACKs then NACKs -> SDA bits 11000101 then 00111010; TxReq twice; WAIT_STOP after NACK.
- Write 0xA0, 0x07, repeated START, 0xA1 read -> RxValid 0x07 with RxFirst=1, then RoW=1 and TxReq fires.
- Write byte with AckEn=0 -> NACK on the 9th bit, following bytes ignored until STOP.
- STOP after 4 bits of a data byte -> no RxValid, state IDLE; Rst=0 pulse while SdaOe=1 -> SdaOe=0 immediately.
